// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared owner/state encoding and default widths for the bus arbiter
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IC_OWN = 2'd1,
    DC_OWN = 2'd2
  } owner_e;

  localparam int BUS_DATA_WIDTH_DEF = 64;
  localparam int BUS_TAG_WIDTH_DEF  = 13;

endpackage

// File: rtl/bus_arbiter_mux.sv
// rtl/bus_arbiter_mux.sv - owner-selected request mux and response demux between two caches and the bus
module bus_arbiter_mux
  import bus_arb_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = BUS_DATA_WIDTH_DEF,
  parameter int BUS_TAG_WIDTH  = BUS_TAG_WIDTH_DEF
) (
  input  owner_e                    owner,
  input  logic                      ic_reqcyc,
  input  logic                      ic_respack,
  input  logic [BUS_DATA_WIDTH-1:0] ic_req,
  input  logic [BUS_TAG_WIDTH-1:0]  ic_reqtag,
  input  logic                      dc_reqcyc,
  input  logic                      dc_respack,
  input  logic [BUS_DATA_WIDTH-1:0] dc_req,
  input  logic [BUS_TAG_WIDTH-1:0]  dc_reqtag,
  output logic                      bus_reqcyc,
  output logic                      bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_respcyc,
  input  logic                      bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      ic_respcyc,
  output logic                      ic_reqack,
  output logic [BUS_DATA_WIDTH-1:0] ic_resp,
  output logic [BUS_TAG_WIDTH-1:0]  ic_resptag,
  output logic                      dc_respcyc,
  output logic                      dc_reqack,
  output logic [BUS_DATA_WIDTH-1:0] dc_resp,
  output logic [BUS_TAG_WIDTH-1:0]  dc_resptag
);

  // Everything not owned is driven to zero so a non-owner can never see stray responses.
  always_comb begin
    bus_reqcyc  = 1'b0;
    bus_respack = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    ic_respcyc  = 1'b0;
    ic_reqack   = 1'b0;
    ic_resp     = '0;
    ic_resptag  = '0;
    dc_respcyc  = 1'b0;
    dc_reqack   = 1'b0;
    dc_resp     = '0;
    dc_resptag  = '0;
    case (owner)
      IC_OWN: begin
        bus_reqcyc  = ic_reqcyc;
        bus_respack = ic_respack;
        bus_req     = ic_req;
        bus_reqtag  = ic_reqtag;
        ic_respcyc  = bus_respcyc;
        ic_reqack   = bus_reqack;
        ic_resp     = bus_resp;
        ic_resptag  = bus_resptag;
      end
      DC_OWN: begin
        bus_reqcyc  = dc_reqcyc;
        bus_respack = dc_respack;
        bus_req     = dc_req;
        bus_reqtag  = dc_reqtag;
        dc_respcyc  = bus_respcyc;
        dc_reqack   = bus_reqack;
        dc_resp     = bus_resp;
        dc_resptag  = bus_resptag;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - icache/dcache system-bus arbiter; BUS_ARB_ROUND_ROBIN_EN selects round-robin tie-break
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = BUS_DATA_WIDTH_DEF,
  parameter int BUS_TAG_WIDTH  = BUS_TAG_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               entry,
  output logic                      ba_bus_reqcyc,
  output logic                      ba_bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] ba_bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  ba_bus_reqtag,
  input  logic                      ba_bus_respcyc,
  input  logic                      ba_bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] ba_bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  ba_bus_resptag,
  input  logic                      ba_icache_assert_bus,
  input  logic                      ba_dcache_assert_bus,
  input  logic                      ba_ic_bus_reqcyc,
  input  logic                      ba_ic_bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] ba_ic_bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  ba_ic_bus_reqtag,
  output logic                      ba_ic_bus_respcyc,
  output logic                      ba_ic_bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] ba_ic_bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  ba_ic_bus_resptag,
  input  logic                      ba_dc_bus_reqcyc,
  input  logic                      ba_dc_bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] ba_dc_bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  ba_dc_bus_reqtag,
  output logic                      ba_dc_bus_respcyc,
  output logic                      ba_dc_bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] ba_dc_bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  ba_dc_bus_resptag,
  output logic                      oba_icache_has_bus,
  output logic                      oba_dcache_has_bus
);

  owner_e state, state_next;
  logic   prefer_ic;
  logic   unused_entry;

  assign unused_entry = ^entry;

`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic last_owner_dc;

  always_ff @(posedge clk) begin
    if (reset)
      last_owner_dc <= 1'b0;
    else if (state_next != IDLE)
      last_owner_dc <= (state_next == DC_OWN);
  end

  assign prefer_ic = last_owner_dc;
`else
  assign prefer_ic = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Owners are never preempted; a release hands straight to a waiting master.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (ba_icache_assert_bus && ba_dcache_assert_bus)
          state_next = prefer_ic ? IC_OWN : DC_OWN;
        else if (ba_dcache_assert_bus)
          state_next = DC_OWN;
        else if (ba_icache_assert_bus)
          state_next = IC_OWN;
      end
      IC_OWN: if (!ba_icache_assert_bus) state_next = ba_dcache_assert_bus ? DC_OWN : IDLE;
      DC_OWN: if (!ba_dcache_assert_bus) state_next = ba_icache_assert_bus ? IC_OWN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign oba_icache_has_bus = (state == IC_OWN);
  assign oba_dcache_has_bus = (state == DC_OWN);

  bus_arbiter_mux #(
    .BUS_DATA_WIDTH(BUS_DATA_WIDTH),
    .BUS_TAG_WIDTH (BUS_TAG_WIDTH)
  ) u_mux (
    .owner      (state),
    .ic_reqcyc  (ba_ic_bus_reqcyc),
    .ic_respack (ba_ic_bus_respack),
    .ic_req     (ba_ic_bus_req),
    .ic_reqtag  (ba_ic_bus_reqtag),
    .dc_reqcyc  (ba_dc_bus_reqcyc),
    .dc_respack (ba_dc_bus_respack),
    .dc_req     (ba_dc_bus_req),
    .dc_reqtag  (ba_dc_bus_reqtag),
    .bus_reqcyc (ba_bus_reqcyc),
    .bus_respack(ba_bus_respack),
    .bus_req    (ba_bus_req),
    .bus_reqtag (ba_bus_reqtag),
    .bus_respcyc(ba_bus_respcyc),
    .bus_reqack (ba_bus_reqack),
    .bus_resp   (ba_bus_resp),
    .bus_resptag(ba_bus_resptag),
    .ic_respcyc (ba_ic_bus_respcyc),
    .ic_reqack  (ba_ic_bus_reqack),
    .ic_resp    (ba_ic_bus_resp),
    .ic_resptag (ba_ic_bus_resptag),
    .dc_respcyc (ba_dc_bus_respcyc),
    .dc_reqack  (ba_dc_bus_reqack),
    .dc_resp    (ba_dc_bus_resp),
    .dc_resptag (ba_dc_bus_resptag)
  );

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter: grants, handoff, forwarding, reset, tie-break
module tb_bus_arbiter;

  localparam int DW = 64;
  localparam int TW = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic [63:0]   entry;
  logic          bus_reqcyc, bus_respack;
  logic [DW-1:0] bus_req;
  logic [TW-1:0] bus_reqtag;
  logic          bus_respcyc, bus_reqack;
  logic [DW-1:0] bus_resp;
  logic [TW-1:0] bus_resptag;
  logic          ic_assert, dc_assert;
  logic          ic_reqcyc, ic_respack, dc_reqcyc, dc_respack;
  logic [DW-1:0] ic_req, dc_req;
  logic [TW-1:0] ic_reqtag, dc_reqtag;
  logic          ic_respcyc, ic_reqack, dc_respcyc, dc_reqack;
  logic [DW-1:0] ic_resp, dc_resp;
  logic [TW-1:0] ic_resptag, dc_resptag;
  logic          ic_has, dc_has;

  always #5 clk = ~clk;

  bus_arbiter dut (
    .clk(clk), .reset(reset), .entry(entry),
    .ba_bus_reqcyc(bus_reqcyc), .ba_bus_respack(bus_respack),
    .ba_bus_req(bus_req), .ba_bus_reqtag(bus_reqtag),
    .ba_bus_respcyc(bus_respcyc), .ba_bus_reqack(bus_reqack),
    .ba_bus_resp(bus_resp), .ba_bus_resptag(bus_resptag),
    .ba_icache_assert_bus(ic_assert), .ba_dcache_assert_bus(dc_assert),
    .ba_ic_bus_reqcyc(ic_reqcyc), .ba_ic_bus_respack(ic_respack),
    .ba_ic_bus_req(ic_req), .ba_ic_bus_reqtag(ic_reqtag),
    .ba_ic_bus_respcyc(ic_respcyc), .ba_ic_bus_reqack(ic_reqack),
    .ba_ic_bus_resp(ic_resp), .ba_ic_bus_resptag(ic_resptag),
    .ba_dc_bus_reqcyc(dc_reqcyc), .ba_dc_bus_respack(dc_respack),
    .ba_dc_bus_req(dc_req), .ba_dc_bus_reqtag(dc_reqtag),
    .ba_dc_bus_respcyc(dc_respcyc), .ba_dc_bus_reqack(dc_reqack),
    .ba_dc_bus_resp(dc_resp), .ba_dc_bus_resptag(dc_resptag),
    .oba_icache_has_bus(ic_has), .oba_dcache_has_bus(dc_has)
  );

  typedef struct {
    logic          ic_has, dc_has;
    logic          b_reqcyc, b_respack;
    logic [DW-1:0] b_req;
    logic [TW-1:0] b_reqtag;
    logic          i_respcyc, i_reqack;
    logic [DW-1:0] i_resp;
    logic [TW-1:0] i_resptag;
    logic          d_respcyc, d_reqack;
    logic [DW-1:0] d_resp;
    logic [TW-1:0] d_resptag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   hold_data = 0;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic randomize_data();
    ic_reqcyc   = 1'($urandom); ic_respack = 1'($urandom);
    dc_reqcyc   = 1'($urandom); dc_respack = 1'($urandom);
    ic_req      = {$urandom, $urandom}; dc_req = {$urandom, $urandom};
    ic_reqtag   = TW'($urandom); dc_reqtag = TW'($urandom);
    bus_respcyc = 1'($urandom); bus_reqack = 1'($urandom);
    bus_resp    = {$urandom, $urandom}; bus_resptag = TW'($urandom);
    entry       = {$urandom, $urandom};
  endtask

  // owner: 0 = nobody, 1 = icache, 2 = dcache, as held after the coming edge.
  task automatic step(input bit rst, input bit ic_a, input bit dc_a, input int owner, input string tag);
    exp_t e;
    exp_t got;
    reset = rst; ic_assert = ic_a; dc_assert = dc_a;
    if (!hold_data) randomize_data();
    e = '{ic_has: (owner == 1), dc_has: (owner == 2),
          b_reqcyc: 1'b0, b_respack: 1'b0, b_req: '0, b_reqtag: '0,
          i_respcyc: 1'b0, i_reqack: 1'b0, i_resp: '0, i_resptag: '0,
          d_respcyc: 1'b0, d_reqack: 1'b0, d_resp: '0, d_resptag: '0};
    if (owner == 1) begin
      e.b_reqcyc = ic_reqcyc; e.b_respack = ic_respack; e.b_req = ic_req; e.b_reqtag = ic_reqtag;
      e.i_respcyc = bus_respcyc; e.i_reqack = bus_reqack; e.i_resp = bus_resp; e.i_resptag = bus_resptag;
    end else if (owner == 2) begin
      e.b_reqcyc = dc_reqcyc; e.b_respack = dc_respack; e.b_req = dc_req; e.b_reqtag = dc_reqtag;
      e.d_respcyc = bus_respcyc; e.d_reqack = bus_reqack; e.d_resp = bus_resp; e.d_resptag = bus_resptag;
    end
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    got = '{ic_has, dc_has, bus_reqcyc, bus_respack, bus_req, bus_reqtag,
            ic_respcyc, ic_reqack, ic_resp, ic_resptag,
            dc_respcyc, dc_reqack, dc_resp, dc_resptag};
    e = exp_q.pop_front();
    check({tag, ".ic_has"},    64'(got.ic_has),    64'(e.ic_has));
    check({tag, ".dc_has"},    64'(got.dc_has),    64'(e.dc_has));
    check({tag, ".bus_reqcyc"},64'(got.b_reqcyc),  64'(e.b_reqcyc));
    check({tag, ".bus_respack"},64'(got.b_respack),64'(e.b_respack));
    check({tag, ".bus_req"},   got.b_req,          e.b_req);
    check({tag, ".bus_reqtag"},64'(got.b_reqtag),  64'(e.b_reqtag));
    check({tag, ".ic_resp"},   {got.i_resp}, {e.i_resp});
    check({tag, ".ic_ctl"},    64'({got.i_respcyc, got.i_reqack, got.i_resptag}),
                               64'({e.i_respcyc, e.i_reqack, e.i_resptag}));
    check({tag, ".dc_resp"},   got.d_resp, e.d_resp);
    check({tag, ".dc_ctl"},    64'({got.d_respcyc, got.d_reqack, got.d_resptag}),
                               64'({e.d_respcyc, e.d_reqack, e.d_resptag}));
  endtask

  initial begin
    reset = 1'b1; ic_assert = 1'b0; dc_assert = 1'b0;
    randomize_data();
    @(negedge clk);

    step(1, 1, 1, 0, "reset_hold");
    step(1, 0, 1, 0, "reset_hold2");
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, "idle");

    // icache alone with the directed request/response values
    hold_data = 1;
    ic_reqcyc = 1'b1; ic_respack = 1'b0; ic_req = 64'h1000; ic_reqtag = 13'h0C00;
    dc_reqcyc = 1'b1; dc_respack = 1'b1; dc_req = 64'h5555; dc_reqtag = 13'h0123;
    bus_respcyc = 1'b1; bus_reqack = 1'b1; bus_resp = 64'hDEAD; bus_resptag = 13'h0C00;
    step(0, 1, 0, 1, "ic_grant");
    step(0, 1, 0, 1, "ic_hold");
    step(0, 0, 0, 0, "ic_release");
    hold_data = 0;

    // simultaneous assert, then zero-gap handoff dcache -> icache
    step(0, 1, 1, 2, "both_dc_first");
    step(0, 1, 1, 2, "both_dc_hold");
    step(0, 1, 0, 1, "handoff_ic");
    step(0, 1, 0, 1, "ic_after_handoff");
    step(0, 0, 0, 0, "ic_release2");

    // dcache asserts during an icache burst: no preemption
    step(0, 1, 0, 1, "burst_grant");
    for (int i = 0; i < 8; i++) begin
      bus_respcyc = 1'b1;
      hold_data = 0;
      step(0, 1, 1, 1, "burst_beat");
    end
    step(0, 0, 1, 2, "burst_handoff_dc");
    step(0, 0, 0, 0, "dc_release");

    // a short dcache pulse under icache ownership is lost
    step(0, 1, 0, 1, "pulse_ic_grant");
    step(0, 1, 1, 1, "pulse_dc");
    step(0, 0, 0, 0, "pulse_lost");

    // reset in the middle of a dcache transaction
    step(0, 0, 1, 2, "rst_dc_grant");
    step(1, 0, 1, 0, "rst_mid_dc");
    step(0, 0, 1, 2, "dc_regrant");
    step(0, 0, 0, 0, "dc_release2");

    // tie-break right after a dcache transaction
`ifdef BUS_ARB_ROUND_ROBIN_EN
    step(0, 1, 1, 1, "tie_after_dc");
    step(0, 0, 0, 0, "tie_release");
    step(0, 1, 1, 2, "tie_after_ic");
`else
    step(0, 1, 1, 2, "tie_after_dc");
    step(0, 0, 0, 0, "tie_release");
    step(0, 1, 1, 2, "tie_again");
`endif
    step(0, 0, 0, 0, "final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master bus arbiter between the instruction cache, the data cache, and the single external system bus. It grants exclusive bus ownership to one cache at a time. It forwards the owner's request-side signals to the bus and routes the bus response back to the owner only. It sits at the top level between `icache`/`dcache` and the SoC bus ports.

## Interface
Parameters:
- `BUS_DATA_WIDTH`, default 64: request/response data width.
- `BUS_TAG_WIDTH`, default 13: request/response tag width.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `entry` in 64: program entry point; unused, present for uniform instantiation.
- `ba_bus_reqcyc`, `ba_bus_respack` out 1: to system bus.
- `ba_bus_req` out BUS_DATA_WIDTH: to system bus.
- `ba_bus_reqtag` out BUS_TAG_WIDTH: to system bus.
- `ba_bus_respcyc`, `ba_bus_reqack` in 1: from system bus.
- `ba_bus_resp` in BUS_DATA_WIDTH: from system bus.
- `ba_bus_resptag` in BUS_TAG_WIDTH: from system bus.
- `ba_icache_assert_bus`, `ba_dcache_assert_bus` in 1: ownership request; held high for the whole transaction.
- `ba_ic_bus_reqcyc`, `ba_ic_bus_respack` in 1: icache request side.
- `ba_ic_bus_req` in BUS_DATA_WIDTH: icache request data.
- `ba_ic_bus_reqtag` in BUS_TAG_WIDTH: icache request tag.
- `ba_ic_bus_respcyc`, `ba_ic_bus_reqack` out 1: icache response side.
- `ba_ic_bus_resp` out BUS_DATA_WIDTH: icache response data.
- `ba_ic_bus_resptag` out BUS_TAG_WIDTH: icache response tag.
- `ba_dc_*` (same eight names with `dc`): identical set for the dcache.
- `oba_icache_has_bus`, `oba_dcache_has_bus` out 1: registered grant.

## Operation
- FSM states: `IDLE`, `IC_OWN`, `DC_OWN`. Reset state is `IDLE`.
- `IDLE`:
  - dcache asserts → `DC_OWN`.
  - Otherwise icache asserts → `IC_OWN`.
  - Both assert → `DC_OWN` (default priority; see Configuration).
- `IC_OWN`: stay while `ba_icache_assert_bus` is 1. When it drops, hand off directly to `DC_OWN` if dcache is asserting, else go to `IDLE`.
- `DC_OWN`: symmetric to `IC_OWN`.
- Grants: `oba_icache_has_bus` = (state==`IC_OWN`); `oba_dcache_has_bus` = (state==`DC_OWN`). Never both 1.
- Request mux (combinational on state): the owner's reqcyc/respack/req/reqtag drive `ba_bus_*`. In `IDLE`, all `ba_bus_*` outputs are 0.
- Response demux: the bus respcyc/reqack/resp/resptag are copied to the owner's outputs. The non-owner's outputs are all 0.
- No arbitration inside a transaction: an owner is never preempted, whatever the other master does.

## Timing
- Grant latency: assert sampled high at edge N (state `IDLE`) → has_bus high after edge N, forwarding active in the same cycle.
- Release: owner's assert sampled low at edge N → its has_bus low after edge N. Handoff to the other master happens at that same edge (zero idle cycles).
- Request and response paths are purely combinational through the arbiter (zero added latency).
- Reset outputs: both has_bus = 0, all `ba_bus_*` = 0, all ic/dc response outputs = 0.
- Reset asserted mid-transaction → `IDLE` at the next edge, regardless of assert inputs.
- An assert that rises and falls while the other master owns the bus is lost; masters must hold assert until granted.

## Configuration
- `BUS_ARB_ROUND_ROBIN_EN` defined: on simultaneous assert in `IDLE`, grant the master that did not own the bus most recently. A 1-bit `last_owner` register, reset to icache, is updated on every grant. The handoff rule is unchanged.
- Not defined: fixed dcache priority, no `last_owner` register.

## Structure
- Shared package `bus_arb_pkg`:
  - owner/state enum `{IDLE, IC_OWN, DC_OWN}`;
  - default width constants 64/13.
- One natural sub-module: `bus_arbiter_mux`, a parameterized two-way request mux plus response demux selected by the owner. The FSM stays in the top.

## Test plan
- Reset, no asserts: all outputs 0 for 10 cycles.
- icache asserts alone with reqcyc=1, req=0x1000, reqtag=0x0C00. Required: has_bus_ic=1 after one edge; bus_req=0x1000, bus_reqtag=0x0C00. Bus resp=0xDEAD, resptag=0x0C00 appear on the ic outputs; dc outputs stay 0.
- Both assert in the same cycle from `IDLE`: dcache granted. icache is granted at the edge where dcache drops assert, with no idle cycle between.
- dcache asserts during an icache 8-beat burst: icache keeps the bus for all 8 respcyc beats, and dcache sees respcyc=0 throughout.
- Reset pulsed while `DC_OWN`: both has_bus = 0 and bus outputs = 0 the next cycle.
- With `BUS_ARB_ROUND_ROBIN_EN`: after a dcache transaction, a simultaneous assert grants icache. Without the macro, the same stimulus grants dcache.
